// File: rtl/fp_pkg.sv
// Shared floating-point constants, the int_to_float state enum and the zero constant.
package fp_pkg;
  localparam int FP_EXP_BIAS = 127;
  localparam int FP_MANT_W   = 23;
  localparam int FP_EXP_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } i2f_state_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
endpackage

// File: rtl/fp_round_rne.sv
// Mantissa rounding stage. Define FP_I2F_ROUND_EN for round-to-nearest-even;
// otherwise the mantissa is truncated.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FP_MANT_W-1:0] mant,
  input  logic                 guard,
  input  logic                 sticky,
  input  logic [FP_EXP_W-1:0]  exp,
  output logic [FP_MANT_W-1:0] mant_rnd,
  output logic [FP_EXP_W-1:0]  exp_rnd
);
`ifdef FP_I2F_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  logic             inc;
  logic [FP_MANT_W:0] sum;

  assign inc = ROUND_EN & guard & (sticky | mant[0]);
  assign sum = {1'b0, mant} + (FP_MANT_W+1)'(inc);

  // A carry out leaves the mantissa at zero and bumps the exponent (1.0 x 2^(e+1)).
  assign mant_rnd = sum[FP_MANT_W-1:0];
  assign exp_rnd  = exp + FP_EXP_W'(sum[FP_MANT_W]);
endmodule

// File: rtl/int_to_float.sv
// Multi-cycle 32-bit integer to IEEE 754 single conversion with valid/ready
// handshakes. Rounding mode selected by macro FP_I2F_ROUND_EN (see fp_round_rne).
module int_to_float
  import fp_pkg::*;
#(
  parameter int SIGNED_IN  = 1,
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);
  i2f_state_t state, state_next;

  logic                 sign;
  logic [31:0]          mag;
  logic [FP_EXP_W-1:0]  exp;
  logic [31:0]          abs_in;
  logic                 accept;
  logic [FP_MANT_W-1:0] mant_rnd;
  logic [FP_EXP_W-1:0]  exp_rnd;

  assign accept = in_valid & in_ready;
  assign abs_in = ((SIGNED_IN != 0) && in_data[31]) ? (~in_data + 32'd1) : in_data;

  fp_round_rne u_round (
    .mant     (mag[30:8]),
    .guard    (mag[7]),
    .sticky   (|mag[6:0]),
    .exp      (exp),
    .mant_rnd (mant_rnd),
    .exp_rnd  (exp_rnd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (accept) state_next = (in_data == 32'd0) ? DONE : NORM;
      NORM:  if (mag[31]) state_next = ROUND;
      ROUND: state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign        <= 1'b0;
      mag         <= '0;
      exp         <= '0;
      out_data    <= FP_ZERO;
      out_inexact <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          sign <= (SIGNED_IN != 0) & in_data[31];
          mag  <= abs_in;
          exp  <= FP_EXP_W'(FP_EXP_BIAS + 31);
          if (in_data == 32'd0) begin
            out_data    <= FP_ZERO;
            out_inexact <= 1'b0;
          end
        end
        NORM: if (!mag[31]) begin
          // Take the wide step only when it cannot push the leading one past bit 31.
          if (mag[31 -: SHIFT_STEP] == '0) begin
            mag <= mag << SHIFT_STEP;
            exp <= exp - FP_EXP_W'(SHIFT_STEP);
          end else begin
            mag <= mag << 1;
            exp <= exp - FP_EXP_W'(1);
          end
        end
        ROUND: begin
          out_data    <= {sign, exp_rnd, mant_rnd};
          out_inexact <= mag[7] | (|mag[6:0]);
        end
        default: ;
      endcase
    end
  end
endmodule
